// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: branch predictor (2-bit saturating BHT) and control-hazard
// flush sequencer for the 5-stage pipeline.
// Optional performance counters are enabled with the macro BRANCH_PERF_CNT_EN;
// without it, branch_cnt and mispredict_cnt are tied to zero.
`timescale 1ns/1ps

module branch_flush_ctrl #(
   parameter int BHT_ENTRIES = 64,
   parameter int FLUSH_LEN   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [31:0] if_pc,
   input  logic [6:0]  if_opcode,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic [6:0]  ex_opcode,
   input  logic        ex_pred_taken,
   input  logic [1:0]  ex_pc_src,
   output logic        redirect,
   output logic        redirect_taken,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispredict_cnt
);

   localparam int          IDX_W      = $clog2(BHT_ENTRIES);
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [2:0]  CNT_INIT   = 3'(FLUSH_LEN - 1);

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   state_e           state_q;
   logic [2:0]       cnt_q;
   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       ctr_d;

   logic [IDX_W-1:0] ifIdx;
   logic [IDX_W-1:0] exIdx;
   logic             exQualified;
   logic             exIsBranch;
   logic             exActual;
   logic             bhtUpdate;
   logic             doRedirect;
   logic             doRedirectTaken;
   logic             unusedPcBits;

   assign ifIdx = if_pc[IDX_W+1:2];
   assign exIdx = ex_pc[IDX_W+1:2];

   // PC bits outside the BHT index do not influence prediction
   assign unusedPcBits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

   // Resolve the EX instruction: decide whether the fetch stream must be redirected
   always_comb begin
      exQualified     = rst_n && (state_q == RUN) && ex_valid && !stall;
      exIsBranch      = (ex_opcode == OPC_BRANCH);
      exActual        = (ex_pc_src == 2'b01);
      bhtUpdate       = exQualified && exIsBranch;
      doRedirect      = 1'b0;
      doRedirectTaken = 1'b0;
      if (exQualified) begin
         if (exIsBranch) begin
            if (exActual != ex_pred_taken) begin
               doRedirect      = 1'b1;
               doRedirectTaken = exActual;
            end
         end else if (ex_pc_src == 2'b11) begin
            doRedirect      = 1'b1;
            doRedirectTaken = 1'b1;
         end
      end
   end

   // Saturating next value for the counter of the branch resolving in EX
   always_comb begin
      ctr_d = bht_q[exIdx];
      if (exActual) begin
         if (bht_q[exIdx] != 2'b11) begin
            ctr_d = bht_q[exIdx] + 2'b01;
         end
      end else begin
         if (bht_q[exIdx] != 2'b00) begin
            ctr_d = bht_q[exIdx] - 2'b01;
         end
      end
   end

   // Branch history table; IF reads the pre-update value in the update cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (bhtUpdate) begin
         bht_q[exIdx] <= ctr_d;
      end
   end

   // RUN/FLUSH sequencer: a redirect opens a flush window of FLUSH_LEN extra cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= 3'd0;
      end else if (!stall) begin
         case (state_q)
            RUN: begin
               if (doRedirect) begin
                  state_q <= FLUSH;
                  cnt_q   <= CNT_INIT;
               end
            end
            FLUSH: begin
               if (cnt_q == 3'd0) begin
                  state_q <= RUN;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: begin
               state_q <= RUN;
               cnt_q   <= 3'd0;
            end
         endcase
      end
   end

   assign pred_taken     = rst_n && (state_q == RUN) && (if_opcode == OPC_BRANCH) && bht_q[ifIdx][1];
   assign redirect       = doRedirect;
   assign redirect_taken = doRedirectTaken;
   assign flush_if_id    = rst_n && ((state_q == FLUSH) || doRedirect);
   assign flush_id_ex    = rst_n && ((state_q == FLUSH) || doRedirect);

`ifdef BRANCH_PERF_CNT_EN
   logic [31:0] branchCnt_q;
   logic [31:0] mispredCnt_q;

   // Performance counters; qualification already excludes stall and FLUSH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branchCnt_q  <= 32'd0;
         mispredCnt_q <= 32'd0;
      end else begin
         if (bhtUpdate) begin
            branchCnt_q <= branchCnt_q + 32'd1;
         end
         if (doRedirect) begin
            mispredCnt_q <= mispredCnt_q + 32'd1;
         end
      end
   end

   assign branch_cnt     = branchCnt_q;
   assign mispredict_cnt = mispredCnt_q;
`else
   assign branch_cnt     = 32'd0;
   assign mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Directed testbench for branch_flush_ctrl (FLUSH_LEN = 2, BHT_ENTRIES = 64).
`timescale 1ns/1ps

module tb_branch_flush_ctrl;

   localparam logic [6:0] OPC_BR  = 7'b1100011;
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic [31:0] if_pc;
   logic [6:0]  if_opcode;
   logic        pred_taken;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [6:0]  ex_opcode;
   logic        ex_pred_taken;
   logic [1:0]  ex_pc_src;
   logic        redirect;
   logic        redirect_taken;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   int total = 0;
   int bad   = 0;

   branch_flush_ctrl #(.BHT_ENTRIES(64), .FLUSH_LEN(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .if_pc          (if_pc),
      .if_opcode      (if_opcode),
      .pred_taken     (pred_taken),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_opcode      (ex_opcode),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pc_src      (ex_pc_src),
      .redirect       (redirect),
      .redirect_taken (redirect_taken),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkFlush(input string tag, input logic exp);
      checkOutput({tag, "_if_id"}, {31'd0, flush_if_id}, {31'd0, exp});
      checkOutput({tag, "_id_ex"}, {31'd0, flush_id_ex}, {31'd0, exp});
   endtask

   task automatic checkCounts(input string tag, input int expBr, input int expMis);
`ifdef BRANCH_PERF_CNT_EN
      checkOutput({tag, "_branch_cnt"}, branch_cnt, 32'(expBr));
      checkOutput({tag, "_mispredict_cnt"}, mispredict_cnt, 32'(expMis));
`else
      if (expBr >= 0 && expMis >= 0) begin
         checkOutput({tag, "_branch_cnt"}, branch_cnt, 32'd0);
         checkOutput({tag, "_mispredict_cnt"}, mispredict_cnt, 32'd0);
      end
`endif
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [6:0] opc,
                                input logic pred, input logic [1:0] src);
      ex_valid      = v;
      ex_pc         = pc;
      ex_opcode     = opc;
      ex_pred_taken = pred;
      ex_pc_src     = src;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Walks the two FLUSH cycles that follow a redirect, then checks the return to RUN
   task automatic runFlushTail(input string tag);
      for (int k = 0; k < 2; k++) begin
         nextCycle();
         applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 2'b00);
         #2;
         checkFlush({tag, "_flush_hold"}, 1'b1);
         checkOutput({tag, "_no_redirect"}, {31'd0, redirect}, 32'd0);
      end
      nextCycle();
      #2;
      checkFlush({tag, "_flush_done"}, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b1;
      stall     = 1'b0;
      if_pc     = 32'h40;
      if_opcode = OPC_BR;
      applyStimulus(1'b1, 32'h40, OPC_BR, 1'b0, 2'b01);
      #1;
      rst_n = 1'b0;
      #1;
      // outputs are forced low during reset even with a mispredict on the ex inputs
      checkOutput("rst_pred", {31'd0, pred_taken}, 32'd0);
      checkOutput("rst_redirect", {31'd0, redirect}, 32'd0);
      checkOutput("rst_redirect_taken", {31'd0, redirect_taken}, 32'd0);
      checkFlush("rst", 1'b0);
      checkCounts("rst", 0, 0);

      nextCycle();
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h40, OPC_BR, 1'b0, 2'b01);
      #2;
      checkOutput("init_pred_0x40", {31'd0, pred_taken}, 32'd0);
      checkOutput("invalid_src01_redirect", {31'd0, redirect}, 32'd0);
      ex_pc_src = 2'b11;
      #2;
      checkOutput("invalid_src11_redirect", {31'd0, redirect}, 32'd0);
      checkFlush("invalid", 1'b0);

      // BEQ at 0x40 resolved taken while predicted not-taken
      nextCycle();
      applyStimulus(1'b1, 32'h40, OPC_BR, 1'b0, 2'b01);
      #2;
      checkOutput("beq_redirect", {31'd0, redirect}, 32'd1);
      checkOutput("beq_redirect_taken", {31'd0, redirect_taken}, 32'd1);
      checkFlush("beq", 1'b1);
      checkOutput("beq_no_bypass_pred", {31'd0, pred_taken}, 32'd0);
      nextCycle();
      #2;
      checkOutput("flush_ignores_ex", {31'd0, redirect}, 32'd0);
      checkOutput("flush_forces_pred0", {31'd0, pred_taken}, 32'd0);
      checkFlush("beq_f1", 1'b1);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 2'b00);
      #2;
      checkFlush("beq_f2", 1'b1);
      nextCycle();
      #2;
      checkFlush("beq_done", 1'b0);
      checkOutput("beq_learned_pred", {31'd0, pred_taken}, 32'd1);
      checkCounts("beq", 1, 1);

      // Three correctly predicted taken resolutions saturate the counter at 11
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 32'h40, OPC_BR, 1'b1, 2'b01);
         #2;
         checkOutput("taken_ok_redirect", {31'd0, redirect}, 32'd0);
         nextCycle();
      end
      checkCounts("taken3", 4, 1);

      // Not-taken while predicted taken: redirect to fallthrough, counter 11 -> 10
      applyStimulus(1'b1, 32'h40, OPC_BR, 1'b1, 2'b00);
      #2;
      checkOutput("nt_redirect", {31'd0, redirect}, 32'd1);
      checkOutput("nt_redirect_taken", {31'd0, redirect_taken}, 32'd0);
      checkFlush("nt", 1'b1);
      runFlushTail("nt");
      checkOutput("nt_pred_still_taken", {31'd0, pred_taken}, 32'd1);
      checkCounts("nt", 5, 2);

      // JAL: always redirects, never touches the BHT or the branch count
      applyStimulus(1'b1, 32'h40, OPC_JAL, 1'b0, 2'b11);
      #2;
      checkOutput("jal_redirect", {31'd0, redirect}, 32'd1);
      checkOutput("jal_redirect_taken", {31'd0, redirect_taken}, 32'd1);
      checkFlush("jal", 1'b1);
      runFlushTail("jal");
      checkOutput("jal_bht_unchanged", {31'd0, pred_taken}, 32'd1);
      checkCounts("jal", 5, 3);

      // Stall in RUN suppresses resolution and holds the BHT
      if_pc = 32'h100;
      applyStimulus(1'b1, 32'h100, OPC_BR, 1'b0, 2'b01);
      stall = 1'b1;
      #2;
      checkOutput("stall_run_redirect", {31'd0, redirect}, 32'd0);
      checkFlush("stall_run", 1'b0);
      nextCycle();
      stall = 1'b0;
      #2;
      checkOutput("stall_bht_held", {31'd0, pred_taken}, 32'd0);
      checkOutput("post_stall_redirect", {31'd0, redirect}, 32'd1);
      checkFlush("post_stall", 1'b1);
      nextCycle();
      stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #2;
         checkFlush("stall_flush_hold", 1'b1);
         checkOutput("stall_flush_redirect", {31'd0, redirect}, 32'd0);
         nextCycle();
      end
      stall = 1'b0;
      applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 2'b00);
      #2;
      checkFlush("unstall_f1", 1'b1);
      nextCycle();
      #2;
      checkFlush("unstall_f2", 1'b1);
      nextCycle();
      #2;
      checkFlush("unstall_run", 1'b0);
      checkOutput("idx0_learned_pred", {31'd0, pred_taken}, 32'd1);
      checkCounts("stall", 6, 4);

      // Reset asserted in the middle of FLUSH
      if_pc = 32'h40;
      applyStimulus(1'b1, 32'h104, OPC_BR, 1'b0, 2'b01);
      #2;
      checkOutput("pre_rst_redirect", {31'd0, redirect}, 32'd1);
      nextCycle();
      #2;
      checkFlush("pre_rst_flush", 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      checkFlush("mid_rst", 1'b0);
      checkOutput("mid_rst_redirect", {31'd0, redirect}, 32'd0);
      checkCounts("mid_rst", 0, 0);
      nextCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 2'b00);
      #2;
      checkFlush("post_rst", 1'b0);
      checkOutput("post_rst_pred_0x40", {31'd0, pred_taken}, 32'd0);
      applyStimulus(1'b1, 32'h104, OPC_BR, 1'b1, 2'b00);
      #2;
      checkOutput("post_rst_run_redirect", {31'd0, redirect}, 32'd1);
      checkOutput("post_rst_run_taken", {31'd0, redirect_taken}, 32'd0);
      nextCycle();
      applyStimulus(1'b0, 32'h0, 7'h0, 1'b0, 2'b00);
      nextCycle();
      nextCycle();
      #2;
      checkFlush("final", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
